timebase: RTL and testbench
===========================

// Module: timebase
// PURPOSE
//  Cycle-accurate system timebase. Divides clk into a periodic tick (1 ms at 10 MHz by default)
//  and keeps a free-running tick counter. Provides N independent countdown channels, each
//  one-shot or periodic, with sticky pending/overrun flags and an OR-ed interrupt.
//  Sits beside the UART/GPIO peripherals in the SoC; software delays and benches time off it.
// PARAMETERS
//  CYCLES_PER_TICK  10000  clk cycles per tick; legal range >= 1 (1 = tick every enabled cycle)
//  N_CHANNELS       4      number of countdown channels; legal range 1..16
//  WIDTH            32     channel count/reload width in ticks
//  TICK_WIDTH       32     free-running tick counter width
// PORTS
//  clk          in   1           core clock
//  rst          in   1           synchronous reset, active-high
//  en           in   1           1 = prescaler runs; 0 = prescaler and tick frozen, state held
//  tick         out  1           one-cycle pulse each CYCLES_PER_TICK enabled cycles
//  tick_count   out  TICK_WIDTH  ticks since reset, wraps
//  ch_load      in   N_CHANNELS  per-channel load strobe
//  ch_load_val  in   WIDTH       count in ticks, shared by all strobed channels
//  ch_periodic  in   N_CHANNELS  mode captured on load: 1 = auto-reload, 0 = one-shot
//  ch_stop      in   N_CHANNELS  per-channel stop strobe
//  ch_clear     in   N_CHANNELS  per-channel clear of pending and overrun
//  ch_active    out  N_CHANNELS  channel is counting
//  ch_pending   out  N_CHANNELS  sticky expiry flag
//  ch_overrun   out  N_CHANNELS  sticky: expired again while pending was still set
//  irq          out  1           |ch_pending (combinational from registers)
// BEHAVIOUR
//  Reset: all registers 0. tick=0, tick_count=0, ch_active=0, ch_pending=0, ch_overrun=0, irq=0.
//  Prescaler presc:
//   - en=1: presc counts 0..CYCLES_PER_TICK-1, then returns to 0.
//   - tick is registered; it is 1 in the cycle after the clock edge where presc was CYCLES_PER_TICK-1.
//   - First tick after reset is high at cycle CYCLES_PER_TICK, counting en=1 cycles after rst drops.
//   - en=0: presc holds and tick=0.
//  tick_count increments by 1 in each cycle where tick=1 and wraps 2^TICK_WIDTH-1 -> 0.
//  Channel FSM, per channel i: states IDLE (ch_active=0), RUN (ch_active=1). Regs: cnt, reload, mode.
//   - IDLE + ch_load[i] + ch_load_val!=0: cnt<=val, reload<=val, mode<=ch_periodic[i] -> RUN.
//   - ch_load with ch_load_val==0: ignored; state, cnt and flags unchanged.
//   - RUN + ch_load: restart with the new value and mode. Pending is not touched.
//   - RUN + tick and cnt>1: cnt<=cnt-1.
//   - RUN + tick and cnt==1 (expiry): ch_pending<=1.
//       ch_overrun<=1 if pending was already 1.
//       Periodic: cnt<=reload, stay RUN. One-shot: cnt<=0 -> IDLE.
//   - ch_stop[i] -> IDLE, cnt<=0. Flags unchanged.
//   - ch_clear[i]: ch_pending<=0, ch_overrun<=0.
//  Timing: a load value of N gives expiry on the Nth tick seen after the load cycle.
//   ch_pending rises the cycle after that tick. irq follows in the same cycle.
//  Priority within one cycle:
//   - stop > load > tick decrement.
//   - A tick coinciding with load is not counted for that channel.
//   - Expiry set beats clear: same cycle -> ch_pending=1, ch_overrun=0 (clear wins overrun only).
//  Channels are fully independent. Several channels may load or expire in the same cycle.
//  rst mid-count: all channels return to IDLE, flags drop, presc=0, on the next edge.
// TESTING (bench uses CYCLES_PER_TICK=4, N_CHANNELS=4, WIDTH=8)
//  1. Release rst, en=1.
//     -> tick pulses at cycles 4, 8, 12, ...; tick_count=3 after the third pulse.
//     -> en=0 for 10 cycles: no ticks; count resumes with no lost phase.
//  2. ch0 one-shot load 3.
//     -> ch_pending[0] and irq rise 1 cycle after the 3rd tick; ch_active[0] falls.
//     -> pending stays set until ch_clear[0]; irq drops the next cycle after the clear.
//  3. ch1 periodic load 2, do not clear.
//     -> pending at tick 2; overrun at tick 4; still active at tick 10.
//     -> ch_clear[1] drops both flags.
//  4. Corner cases:
//     -> load ch2 in the same cycle as a tick: expiry one tick later than a non-coincident load.
//     -> load+stop in the same cycle: stays IDLE.
//     -> load value 0: ignored.
//  5. Clear on the expiry cycle -> pending=1. Assert rst with ch0-ch3 running -> all outputs 0.
//  6. TICK_WIDTH=4: 17 ticks -> tick_count wraps to 1.

Source files
------------

// File: rtl/timebase.sv
// System timebase: prescaled tick, free-running tick counter and N countdown
// channels (one-shot or periodic) with sticky pending/overrun flags and an OR-ed irq.
module timebase #(
    parameter int unsigned CYCLES_PER_TICK = 10000,
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned TICK_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  tick,
    output logic [TICK_WIDTH-1:0] tick_count,
    input  logic [N_CHANNELS-1:0] ch_load,
    input  logic [WIDTH-1:0]      ch_load_val,
    input  logic [N_CHANNELS-1:0] ch_periodic,
    input  logic [N_CHANNELS-1:0] ch_stop,
    input  logic [N_CHANNELS-1:0] ch_clear,
    output logic [N_CHANNELS-1:0] ch_active,
    output logic [N_CHANNELS-1:0] ch_pending,
    output logic [N_CHANNELS-1:0] ch_overrun,
    output logic                  irq
);

    localparam int unsigned PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_TICK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [TICK_WIDTH-1:0] tick_count_q, tick_count_d;

    ch_state_e             state_q  [N_CHANNELS];
    ch_state_e             state_d  [N_CHANNELS];
    logic [WIDTH-1:0]      cnt_q    [N_CHANNELS];
    logic [WIDTH-1:0]      cnt_d    [N_CHANNELS];
    logic [WIDTH-1:0]      reload_q [N_CHANNELS];
    logic [WIDTH-1:0]      reload_d [N_CHANNELS];
    logic [N_CHANNELS-1:0] mode_q, mode_d;
    logic [N_CHANNELS-1:0] pending_q, pending_d;
    logic [N_CHANNELS-1:0] overrun_q, overrun_d;
    logic [N_CHANNELS-1:0] load_ok;
    logic [N_CHANNELS-1:0] expire;

    // Prescaler and tick counter; en=0 freezes the phase and suppresses the tick.
    always_comb begin
        presc_d      = presc_q;
        tick_d       = 1'b0;
        tick_count_d = tick_q ? tick_count_q + 1'b1 : tick_count_q;
        if (en) begin
            tick_d  = (presc_q == PRESC_MAX);
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
        end
    end

    // A zero load value is treated as no load at all.
    assign load_ok = ch_load & {N_CHANNELS{ch_load_val != '0}};

    // Channel FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i]  <= IDLE;
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
            mode_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
            end
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Channel FSM: next state. Priority is stop, then load, then tick decrement.
    always_comb begin
        mode_d = mode_q;
        expire = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];
            if (ch_stop[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (load_ok[i]) begin
                state_d[i]  = RUN;
                cnt_d[i]    = ch_load_val;
                reload_d[i] = ch_load_val;
                mode_d[i]   = ch_periodic[i];
            end else if (state_q[i] == RUN && tick_q) begin
                if (cnt_q[i] > WIDTH'(1)) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    expire[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = reload_q[i];
                    end else begin
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end
                end
            end
        end
        // Expiry beats clear for pending; clear always wins for overrun.
        pending_d = expire | (pending_q & ~ch_clear);
        overrun_d = ~ch_clear & (overrun_q | (expire & pending_q));
    end

    // Channel FSM: outputs.
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            ch_active[i] = (state_q[i] == RUN);
        end
    end

    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign ch_pending = pending_q;
    assign ch_overrun = overrun_q;
    assign irq        = |pending_q;

endmodule

// File: tb/tb_timebase.sv
// Bench for timebase: a deadline-based reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_timebase;

  localparam int CPT = 4;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TW  = 4;
  localparam int EW  = 1 + TW + 3 * N;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          tick;
  logic [TW-1:0] tick_count;
  logic [N-1:0]  ch_load = '0;
  logic [W-1:0]  ch_load_val = '0;
  logic [N-1:0]  ch_periodic = '0;
  logic [N-1:0]  ch_stop = '0;
  logic [N-1:0]  ch_clear = '0;
  logic [N-1:0]  ch_active;
  logic [N-1:0]  ch_pending;
  logic [N-1:0]  ch_overrun;
  logic          irq;

  timebase #(
    .CYCLES_PER_TICK(CPT),
    .N_CHANNELS     (N),
    .WIDTH          (W),
    .TICK_WIDTH     (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tick       (tick),
    .tick_count (tick_count),
    .ch_load    (ch_load),
    .ch_load_val(ch_load_val),
    .ch_periodic(ch_periodic),
    .ch_stop    (ch_stop),
    .ch_clear   (ch_clear),
    .ch_active  (ch_active),
    .ch_pending (ch_pending),
    .ch_overrun (ch_overrun),
    .irq        (irq)
  );

  // reference model: channels hold the absolute tick number at which they expire
  bit    m_tick;
  longint m_ticks;
  longint m_en_cycles;
  bit    m_active [N];
  longint m_deadline [N];
  longint m_reload [N];
  bit    m_per [N];
  bit    m_pend [N];
  bit    m_ov [N];

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_tick = 1'b0;
      m_ticks = 0;
      m_en_cycles = 0;
      for (int i = 0; i < N; i++) begin
        m_active[i] = 1'b0;
        m_deadline[i] = 0;
        m_reload[i] = 0;
        m_per[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_ov[i] = 1'b0;
      end
    end else begin
      bit t;
      t = m_tick;
      for (int i = 0; i < N; i++) begin
        bit expire;
        expire = 1'b0;
        if (ch_stop[i]) begin
          m_active[i] = 1'b0;
        end else if (ch_load[i] && ch_load_val != 0) begin
          m_active[i] = 1'b1;
          m_deadline[i] = m_ticks + longint'(t) + longint'(ch_load_val);
          m_reload[i] = longint'(ch_load_val);
          m_per[i] = ch_periodic[i];
        end else if (m_active[i] && t && m_deadline[i] == m_ticks + 1) begin
          expire = 1'b1;
          if (m_per[i]) m_deadline[i] = m_deadline[i] + m_reload[i];
          else m_active[i] = 1'b0;
        end
        m_ov[i] = !ch_clear[i] && (m_ov[i] || (expire && m_pend[i]));
        m_pend[i] = expire || (m_pend[i] && !ch_clear[i]);
      end
      m_ticks = m_ticks + longint'(t);
      if (en) begin
        m_en_cycles++;
        m_tick = (m_en_cycles % CPT) == 0;
      end else begin
        m_tick = 1'b0;
      end
    end
  endtask

  function automatic logic [EW-1:0] snapshot();
    logic [N-1:0] a, p, o;
    for (int i = 0; i < N; i++) begin
      a[i] = m_active[i];
      p[i] = m_pend[i];
      o[i] = m_ov[i];
    end
    return {m_tick, TW'(m_ticks), a, p, o};
  endfunction

  // driver tasks
  task automatic step();
    model_update();
    @(posedge clk);
    exp_q.push_back(snapshot());
    #1;
    ch_load = '0;
    ch_stop = '0;
    ch_clear = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tick_phase();
    int n;
    n = 0;
    while (!m_tick && n < 4 * CPT) begin
      step();
      n++;
    end
    if (!m_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_phase_timeout: got 0 expected 1");
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("tick",       32'(tick),       32'(e[EW-1]));
      check("tick_count", 32'(tick_count), 32'(e[EW-2 -: TW]));
      check("active",     32'(ch_active),  32'(e[3*N-1 -: N]));
      check("pending",    32'(ch_pending), 32'(e[2*N-1 -: N]));
      check("overrun",    32'(ch_overrun), 32'(e[N-1:0]));
      check("irq",        32'(irq),        32'(|e[2*N-1 -: N]));
    end
  end

  initial begin
    // 1: reset, tick cadence, en freeze
    rst = 1'b1;
    cycles(2);
    check("rst_tick_count", 32'(tick_count), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    en = 1'b1;
    cycles(13);
    check("tick_count_3", 32'(tick_count), 3);
    en = 1'b0;
    cycles(10);
    check("frozen_count", 32'(tick_count), 3);
    check("frozen_tick", 32'(tick), 0);
    en = 1'b1;
    cycles(5);

    // 2: ch0 one-shot load 3
    ch_load[0] = 1'b1;
    ch_load_val = 8'd3;
    ch_periodic[0] = 1'b0;
    step();
    cycles(12);
    check("os_pending", 32'(ch_pending[0]), 1);
    check("os_active", 32'(ch_active[0]), 0);
    check("os_irq", 32'(irq), 1);
    cycles(3);
    check("os_sticky", 32'(ch_pending[0]), 1);
    ch_clear[0] = 1'b1;
    step();
    check("os_cleared", 32'(ch_pending[0]), 0);
    check("os_irq_drop", 32'(irq), 0);

    // 3: ch1 periodic load 2
    ch_load[1] = 1'b1;
    ch_load_val = 8'd2;
    ch_periodic[1] = 1'b1;
    step();
    cycles(45);
    check("per_active", 32'(ch_active[1]), 1);
    check("per_pending", 32'(ch_pending[1]), 1);
    check("per_overrun", 32'(ch_overrun[1]), 1);
    ch_clear[1] = 1'b1;
    ch_stop[1] = 1'b1;
    step();
    check("per_clr_pend", 32'(ch_pending[1]), 0);
    check("per_clr_ovr", 32'(ch_overrun[1]), 0);

    // 4: load coincident with tick, load+stop, zero load
    wait_tick_phase();
    ch_load[2] = 1'b1;
    ch_load_val = 8'd2;
    ch_periodic[2] = 1'b0;
    step();
    cycles(7);
    check("coinc_early", 32'(ch_pending[2]), 0);
    step();
    check("coinc_late", 32'(ch_pending[2]), 1);
    ch_load[3] = 1'b1;
    ch_stop[3] = 1'b1;
    ch_load_val = 8'd5;
    step();
    check("load_stop", 32'(ch_active[3]), 0);
    ch_load[0] = 1'b1;
    ch_load_val = 8'd0;
    step();
    check("load_zero", 32'(ch_active[0]), 0);

    // 5: clear on the expiry cycle, then reset with all channels running
    wait_tick_phase();
    step();
    ch_load[0] = 1'b1;
    ch_load_val = 8'd1;
    ch_periodic[0] = 1'b0;
    step();
    wait_tick_phase();
    ch_clear[0] = 1'b1;
    step();
    check("clr_exp_pend", 32'(ch_pending[0]), 1);
    check("clr_exp_ovr", 32'(ch_overrun[0]), 0);
    ch_load = '1;
    ch_load_val = 8'd50;
    ch_periodic = '1;
    step();
    cycles(3);
    rst = 1'b1;
    step();
    check("rst_active", 32'(ch_active), 0);
    check("rst_pending", 32'(ch_pending), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_count", 32'(tick_count), 0);
    rst = 1'b0;

    // 6: 17 ticks wrap a 4-bit counter to 1
    cycles(17 * CPT + 1);
    check("wrap_17", 32'(tick_count), 1);

    // randomized phase
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        ch_load[i] = ($urandom_range(0, 11) == 0);
        ch_periodic[i] = 1'($urandom_range(0, 1));
        ch_stop[i] = ($urandom_range(0, 39) == 0);
        ch_clear[i] = ($urandom_range(0, 5) == 0);
      end
      ch_load_val = 8'($urandom_range(0, 6));
      step();
    end
    rst = 1'b0;

    // final report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
